// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// results held in output registers until the next completion.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W1 = WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] qreg_q, qreg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  // One restoring step: shift {rem, q} left, try subtracting the divisor.
  always_comb begin
    rem_sh   = W1'({rem_q, qreg_q[WIDTH-1]});
    trial    = rem_sh - {1'b0, divisor_q};
    rem_next = trial[WIDTH] ? rem_sh : trial;
    q_next   = {qreg_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qreg_d      = qreg_q;
    divisor_d   = divisor_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor != '0) begin
            rem_d     = '0;
            qreg_d    = dividend;
            divisor_d = divisor;
            cnt_d     = CW'(WIDTH);
            dbz_d     = 1'b0;
            state_d   = RUN;
          end else begin
            // Divide by zero completes immediately with a fixed result.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end
        end
      end
      RUN: begin
        rem_d  = rem_next;
        qreg_d = q_next;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quotient_d  = q_next;
          remainder_d = rem_next[WIDTH-1:0];
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      qreg_q      <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      qreg_q      <= qreg_d;
      divisor_q   <= divisor_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=8) with hand-computed results.
module tb_seq_divider;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one division and follow it to its done pulse.
  task automatic run_div(input string tag, input int a, input int b,
                         input int exp_q, input int exp_r, input int exp_dbz);
    int cyc;
    int busy_cnt;
    int overlap;
    start    = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    tick();
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 8'h00;
    cyc = 1; busy_cnt = 0; overlap = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
    if (busy && done) overlap = 1;
    $display("%s: %0d/%0d -> q=%0d r=%0d dbz=%0d after %0d cycles",
             tag, a, b, quotient, remainder, div_by_zero, cyc);
    check({tag, "_latency"}, cyc, (b == 0) ? 1 : WIDTH + 1);
    check({tag, "_busy_cycles"}, busy_cnt, (b == 0) ? 0 : WIDTH);
    check({tag, "_overlap"}, overlap, 0);
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_remainder"}, remainder, exp_r);
    check({tag, "_dbz"}, div_by_zero, exp_dbz);
    tick();
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_hold_q"}, quotient, exp_q);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int first_done;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    #10 rst_n = 1'b1;
    tick();

    run_div("basic",     100, 7,   14,  2,  0);
    run_div("by_one",    255, 1,   255, 0,  0);
    run_div("small",     5,   9,   0,   5,  0);
    run_div("equal",     255, 255, 1,   0,  0);
    run_div("div_zero",  37,  0,   255, 37, 1);
    run_div("clear_dbz", 20,  3,   6,   2,  0);

    // Start while busy: second request on cycle 3 must be ignored.
    start = 1'b1; dividend = 8'd200; divisor = 8'd9;
    tick();
    start = 1'b0;
    cyc = 1; done_cnt = 0; first_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (cyc == 3) begin start = 1'b1; dividend = 8'd10; divisor = 8'd2; end
      else start = 1'b0;
      tick();
      cyc++;
      if (done) begin
        done_cnt++;
        if (first_done == 0) begin
          first_done = cyc;
          check("busy_start_quotient", quotient, 22);
          check("busy_start_remainder", remainder, 2);
        end
      end
    end
    start = 1'b0;
    $display("start_while_busy: done pulses=%0d first at cycle %0d q=%0d r=%0d",
             done_cnt, first_done, quotient, remainder);
    check("busy_start_done_count", done_cnt, 1);
    check("busy_start_latency", first_done, WIDTH + 1);

    // Back-to-back: second start accepted in the DONE cycle.
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin tick(); cyc++; end
    $display("b2b_first: 50/6 -> q=%0d r=%0d at cycle %0d", quotient, remainder, cyc);
    check("b2b_first_q", quotient, 8);
    check("b2b_first_r", remainder, 2);
    start = 1'b1; dividend = 8'd81; divisor = 8'd4;
    tick();
    cyc++;
    start = 1'b0;
    check("b2b_no_bubble_busy", busy, 1);
    check("b2b_no_bubble_done", done, 0);
    check("b2b_hold_q", quotient, 8);
    while (!done && cyc < 60) begin tick(); cyc++; end
    $display("b2b_second: 81/4 -> q=%0d r=%0d at cycle %0d", quotient, remainder, cyc);
    check("b2b_second_q", quotient, 20);
    check("b2b_second_r", remainder, 1);
    check("b2b_total_cycles", cyc, 2 * (WIDTH + 1));
    tick();

    // Reset mid-operation aborts without completion.
    start = 1'b1; dividend = 8'd123; divisor = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    $display("reset_mid_op: busy=%0d done=%0d q=%0d r=%0d dbz=%0d",
             busy, done, quotient, remainder, div_by_zero);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    #3 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    check("midrst_stays_idle", done_cnt, 0);
    run_div("after_rst", 123, 5, 24, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
